// File: rtl/parse_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : Parser_PKG
//  Description : Shared defaults and helpers for the parse sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package Parser_PKG;

  localparam int PARSER_NUM_SUB        = 4;
  localparam int PARSER_TIMEOUT_CYCLES = 1024;

  // Index width that stays legal (at least one bit) for a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parse_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : parse_sequencer_if
//  Description : Subparser handshake bus plus the shared character reader
//                port. The master side is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface parse_sequencer_if
  import Parser_PKG::*;
#(
  parameter int NUM_SUB = PARSER_NUM_SUB
);

  logic [NUM_SUB-1:0] sub_trigger;
  logic [NUM_SUB-1:0] sub_rdy;
  logic [NUM_SUB-1:0] sub_success;
  logic [NUM_SUB-1:0] sub_rd_trigger;
  logic [NUM_SUB-1:0] sub_rd_rdy;
  logic [NUM_SUB-1:0] sub_rd_done;
  logic               rd_trigger;
  logic               rd_rdy;
  logic               rd_done;
  logic               is_empty;

  modport master (
    output sub_trigger, sub_rd_rdy, sub_rd_done, rd_trigger,
    input  sub_rdy, sub_success, sub_rd_trigger, rd_rdy, rd_done, is_empty
  );

  modport slave (
    input  sub_trigger, sub_rd_rdy, sub_rd_done, rd_trigger,
    output sub_rdy, sub_success, sub_rd_trigger, rd_rdy, rd_done, is_empty
  );

endinterface
`default_nettype wire

// File: rtl/parse_sequencer_reader_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ReaderMux
//  Description : Routes the single shared character reader to the subparser
//                currently holding the grant; everyone else sees it idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ReaderMux
  import Parser_PKG::*;
#(
  parameter  int NUM_SUB = PARSER_NUM_SUB,
  localparam int IDX_W   = idx_width(NUM_SUB)
)(
  input  logic               grant_valid,
  input  logic [IDX_W-1:0]   grant_idx,
  input  logic [NUM_SUB-1:0] sub_rd_trigger,
  input  logic               rd_rdy,
  input  logic               rd_done,
  output logic               rd_trigger,
  output logic [NUM_SUB-1:0] sub_rd_rdy,
  output logic [NUM_SUB-1:0] sub_rd_done
);

  // Zero-latency routing: only the granted lane is connected.
  always_comb begin
    rd_trigger  = 1'b0;
    sub_rd_rdy  = '0;
    sub_rd_done = '0;
    if (grant_valid) begin
      rd_trigger             = sub_rd_trigger[grant_idx];
      sub_rd_rdy[grant_idx]  = rd_rdy;
      sub_rd_done[grant_idx] = rd_done;
    end
  end

endmodule
`default_nettype wire

// File: rtl/parse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : parse_sequencer
//  Description : Runs NUM_SUB subparsers one after another, aborting on the
//                first failure, on end of input, or when a subparser stays
//                busy past the watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module parse_sequencer
  import Parser_PKG::*;
#(
  parameter  int NUM_SUB        = PARSER_NUM_SUB,
  parameter  int TIMEOUT_CYCLES = PARSER_TIMEOUT_CYCLES,
  localparam int IDX_W          = idx_width(NUM_SUB),
  localparam int WD_W           = idx_width(TIMEOUT_CYCLES)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             trigger,
  output logic             rdy,
  output logic             done,
  output logic             success,
  output logic [IDX_W-1:0] fail_idx,
  output logic             timeout,
  parse_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SUB_TRIGGER = 3'd1,
    SUB_WAIT    = 3'd2,
    SUB_CHECK   = 3'd3,
    ABORT       = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SUB - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_nxt;
  logic               success_nxt, timeout_nxt;
  logic [IDX_W-1:0]   fail_idx_nxt;
  logic [NUM_SUB-1:0] sub_trig;
  logic               grant_valid;

  // State and result registers; clk_en freezes everything, reset overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wd_cnt   <= '0;
      success  <= 1'b0;
      timeout  <= 1'b0;
      fail_idx <= '0;
    end else if (clk_en) begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wd_cnt   <= wd_nxt;
      success  <= success_nxt;
      timeout  <= timeout_nxt;
      fail_idx <= fail_idx_nxt;
    end
  end

  // Next-state, watchdog and status logic plus the Moore-style outputs.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wd_nxt       = wd_cnt;
    success_nxt  = success;
    timeout_nxt  = timeout;
    fail_idx_nxt = fail_idx;
    rdy          = 1'b0;
    done         = 1'b0;
    sub_trig     = '0;
    grant_valid  = 1'b0;
    case (state)
      IDLE: begin
        rdy  = 1'b1;
        done = 1'b1;
        if (trigger && bus.rd_rdy && !bus.is_empty) begin
          state_nxt    = SUB_TRIGGER;
          idx_nxt      = '0;
          wd_nxt       = '0;
          success_nxt  = 1'b0;
          timeout_nxt  = 1'b0;
          fail_idx_nxt = '0;
        end
      end
      SUB_TRIGGER: begin
        sub_trig[idx] = 1'b1;
        grant_valid   = 1'b1;
        if (wd_cnt == WD_LAST) begin
          timeout_nxt  = 1'b1;
          fail_idx_nxt = idx;
          state_nxt    = ABORT;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
          if (!bus.sub_rdy[idx]) state_nxt = SUB_WAIT;
        end
      end
      SUB_WAIT: begin
        grant_valid = 1'b1;
        if (wd_cnt == WD_LAST) begin
          timeout_nxt  = 1'b1;
          fail_idx_nxt = idx;
          state_nxt    = ABORT;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
          // A subparser returning to ready marks its completion.
          if (bus.sub_rdy[idx]) state_nxt = SUB_CHECK;
        end
      end
      SUB_CHECK: begin
        grant_valid = 1'b1;
        if (!bus.sub_success[idx]) begin
          fail_idx_nxt = idx;
          state_nxt    = ABORT;
        end else if (idx == IDX_LAST) begin
          success_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (bus.is_empty) begin
          // Input ran out before the next subparser could start.
          fail_idx_nxt = idx + 1'b1;
          state_nxt    = ABORT;
        end else begin
          idx_nxt   = idx + 1'b1;
          wd_nxt    = '0;
          state_nxt = SUB_TRIGGER;
        end
      end
      ABORT: begin
        success_nxt = 1'b0;
        state_nxt   = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sub_trigger = sub_trig;

  ReaderMux #(
    .NUM_SUB (NUM_SUB)
  ) u_reader_mux (
    .grant_valid    (grant_valid),
    .grant_idx      (idx),
    .sub_rd_trigger (bus.sub_rd_trigger),
    .rd_rdy         (bus.rd_rdy),
    .rd_done        (bus.rd_done),
    .rd_trigger     (bus.rd_trigger),
    .sub_rd_rdy     (bus.sub_rd_rdy),
    .sub_rd_done    (bus.sub_rd_done)
  );

endmodule
`default_nettype wire

// File: doc/parse_sequencer.md
PARSE_SEQUENCER -- requirements
Module: parse_sequencer

Interface
REQ-001 Parameter NUM_SUB, default 4: number of subparsers sequenced, index 0 first.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum clk_en cycles a single subparser may stay busy.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clk_en  in  1  module enabling clock; state, counters and flags advance only when high.
REQ-006 trigger  in  1  start one full parse sequence.
REQ-007 rdy  out  1  ready to accept trigger.
REQ-008 done  out  1  sequence finished; also high in IDLE.
REQ-009 success  out  1  all subparsers reported success in the last sequence.
REQ-010 fail_idx  out  $clog2(NUM_SUB)  index of the subparser that failed or timed out.
REQ-011 timeout  out  1  last sequence aborted by the watchdog.
REQ-012 sub_trigger  out  NUM_SUB  per-subparser trigger.
REQ-013 sub_rdy  in  NUM_SUB  per-subparser ready.
REQ-014 sub_success  in  NUM_SUB  per-subparser success flag.
REQ-015 sub_rd_trigger  in  NUM_SUB  per-subparser character-read request.
REQ-016 sub_rd_rdy  out  NUM_SUB  reader ready, routed to the granted subparser.
REQ-017 sub_rd_done  out  NUM_SUB  reader done, routed to the granted subparser.
REQ-018 rd_trigger  out  1  to the shared character reader.
REQ-019 rd_rdy  in  1  from the shared reader.
REQ-020 rd_done  in  1  from the shared reader.
REQ-021 is_empty  in  1  no more characters available.

Function
REQ-022 States: IDLE, SUB_TRIGGER, SUB_WAIT, SUB_CHECK, ABORT, DONE.
REQ-023 IDLE: rdy=1, done=1, sub_trigger=0; on trigger & rd_rdy & !is_empty, go to SUB_TRIGGER with idx=0 and clear success, timeout and fail_idx; otherwise the trigger is ignored.
REQ-024 SUB_TRIGGER: sub_trigger[idx]=1; leave for SUB_WAIT when sub_rdy[idx]=0.
REQ-025 SUB_WAIT: sub_trigger=0; go to SUB_CHECK when sub_rdy[idx] returns to 1, because a subparser's return to ready marks its completion.
REQ-026 SUB_CHECK: if sub_success[idx]=0, go to ABORT with fail_idx=idx; else if idx=NUM_SUB-1, set success=1 and go to DONE; else idx+1, then SUB_TRIGGER.
REQ-027 SUB_CHECK with is_empty=1 and idx<NUM_SUB-1: go to ABORT with fail_idx=idx+1.
REQ-028 Watchdog: counter cleared on entry to SUB_TRIGGER and incremented each clk_en cycle in SUB_TRIGGER/SUB_WAIT; at TIMEOUT_CYCLES-1, set timeout=1, fail_idx=idx and go to ABORT.
REQ-029 ABORT: success=0, held 1 cycle, then DONE.
REQ-030 DONE: done=1, rdy=0, held 1 cycle, then IDLE.
REQ-031 Reader grant = idx in SUB_TRIGGER/SUB_WAIT/SUB_CHECK; no grant otherwise.
REQ-032 Granted subparser: rd_trigger=sub_rd_trigger[idx], sub_rd_rdy[idx]=rd_rdy and sub_rd_done[idx]=rd_done.
REQ-033 Non-granted subparsers see sub_rd_rdy=0 and sub_rd_done=0; their sub_rd_trigger is ignored; rd_trigger=0 when there is no grant.
REQ-034 Reader routing is combinational, with zero-cycle latency.
REQ-035 success, timeout and fail_idx are registered and held until the next accepted trigger.
REQ-036 A trigger outside IDLE is ignored.
REQ-037 clk_en=0 freezes all state and counters; combinational outputs still follow the current state.

Reset
REQ-038 Reset forces: state IDLE, idx 0, watchdog 0, success 0, timeout 0, fail_idx 0, sub_trigger 0, rd_trigger 0.
REQ-039 Reset has priority over clk_en and takes effect mid-sequence in one cycle.

Structure
REQ-040 Package Parser_PKG holds PARSER_NUM_SUB and PARSER_TIMEOUT_CYCLES; the state enum stays local to the module.
REQ-041 One combinational sub-module, ReaderMux, implements REQ-031..REQ-034 from grant_valid and grant_idx.

Verification
REQ-042 Four stub subparsers, each succeeding after 5 cycles, one trigger -> sub_trigger order 0,1,2,3; success=1, done pulse, rdy=1 again 1 cycle after DONE.
REQ-043 Stub 1 returns sub_success=0 -> stubs 2 and 3 never triggered; success=0, fail_idx=1, timeout=0.
REQ-044 Stub 2 never returns ready, TIMEOUT_CYCLES=16 -> ABORT 16 clk_en cycles after entering SUB_TRIGGER; timeout=1, fail_idx=2.
REQ-045 Stub 0 asserts sub_rd_trigger while stub 1 is granted -> rd_trigger follows stub 1 only; sub_rd_rdy[0]=0 throughout.
REQ-046 is_empty=1 at trigger -> stays IDLE; is_empty rising after stub 0 completes -> ABORT, fail_idx=1.
REQ-047 Reset asserted in SUB_WAIT -> next cycle IDLE, all outputs at reset values; clk_en held low for 10 cycles mid-sequence -> state and watchdog unchanged.
